// File: rtl/btb_predictor_pkg.sv
// btb_predictor_pkg: counter encodings and saturating helpers shared by the BTB
package btb_predictor_pkg;
  localparam logic [1:0] SN = 2'b00;
  localparam logic [1:0] WN = 2'b01;
  localparam logic [1:0] WT = 2'b10;
  localparam logic [1:0] ST = 2'b11;
  localparam logic [1:0] CTR_RESET = WN;
  localparam logic [1:0] CTR_ALLOC = WT;
  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == ST) ? ST : c + 2'd1;
  endfunction
  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == SN) ? SN : c - 2'd1;
  endfunction
endpackage

// File: rtl/btb_predictor_perf.sv
// btb_perf_counters: lookup and mispredict event counters, wrapping modulo 2^32
module btb_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        lookup_inc,
  input  logic        mispred_inc,
  output logic [31:0] lookup_cnt,
  output logic [31:0] mispred_cnt
);
  always_ff @(posedge clk) begin
    if (rst) begin
      lookup_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      lookup_cnt  <= lookup_cnt + {31'd0, lookup_inc};
      mispred_cnt <= mispred_cnt + {31'd0, mispred_inc};
    end
  end
endmodule

// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped BTB with 2-bit direction counters, async-read lookup
module btb_predictor
  import btb_predictor_pkg::*;
#(
  parameter int ENTRY_BITS = 6,
  parameter int TAG_BITS   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic        BranchPredictedF,
  output logic [31:0] BranchPredictedTargetF,
  input  logic        BrInstE,
  input  logic [31:0] PCE,
  input  logic        BranchE,
  input  logic [31:0] BranchTarget,
  input  logic        BranchPredictedE,
  input  logic        StallE,
  output logic [31:0] LookupCnt,
  output logic [31:0] MispredCnt
);
  localparam int N  = 1 << ENTRY_BITS;
  localparam int HI = 2 + ENTRY_BITS + TAG_BITS;
  logic                  valid   [N];
  logic [TAG_BITS-1:0]   tags    [N];
  logic [31:0]           targets [N];
  logic [1:0]            ctrs    [N];
  logic [ENTRY_BITS-1:0] idx_f, idx_e;
  logic [TAG_BITS-1:0]   tag_f, tag_e;
  logic                  hit_f, hit_e, trn;
  logic                  unused_pc;
  assign idx_f = PCF[2 +: ENTRY_BITS];
  assign idx_e = PCE[2 +: ENTRY_BITS];
  assign tag_f = PCF[2 + ENTRY_BITS +: TAG_BITS];
  assign tag_e = PCE[2 + ENTRY_BITS +: TAG_BITS];
  assign unused_pc = ^{PCF[31:HI], PCF[1:0], PCE[31:HI], PCE[1:0]};
  assign hit_f = valid[idx_f] && (tags[idx_f] == tag_f);
  assign hit_e = valid[idx_e] && (tags[idx_e] == tag_e);
  assign trn   = BrInstE & ~StallE & ~rst;
  // gated by rst so the reset cycle never predicts from stale entries
  assign BranchPredictedF       = ~rst & hit_f & ctrs[idx_f][1];
  assign BranchPredictedTargetF = BranchPredictedF ? targets[idx_f] : 32'h0;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        valid[i]   <= 1'b0;
        tags[i]    <= '0;
        targets[i] <= '0;
        ctrs[i]    <= CTR_RESET;
      end
    end else if (trn) begin
      if (hit_e) begin
        ctrs[idx_e] <= BranchE ? sat_inc(ctrs[idx_e]) : sat_dec(ctrs[idx_e]);
        if (BranchE) targets[idx_e] <= BranchTarget;
      end else if (BranchE) begin
        valid[idx_e]   <= 1'b1;
        tags[idx_e]    <= tag_e;
        targets[idx_e] <= BranchTarget;
        ctrs[idx_e]    <= CTR_ALLOC;
      end
    end
  end
  btb_perf_counters u_perf (
    .clk         (clk),
    .rst         (rst),
    .lookup_inc  (trn),
    .mispred_inc (trn & (BranchE ^ BranchPredictedE)),
    .lookup_cnt  (LookupCnt),
    .mispred_cnt (MispredCnt)
  );
endmodule

// File: tb/tb_btb_predictor.sv
// tb_btb_predictor: directed plus random checks against a behavioural BTB model
module tb_btb_predictor;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] PCF = '0, PCE = '0, BranchTarget = '0;
  logic        BrInstE = 1'b0, BranchE = 1'b0, BranchPredictedE = 1'b0, StallE = 1'b0;
  logic        BranchPredictedF;
  logic [31:0] BranchPredictedTargetF, LookupCnt, MispredCnt;
  int vectors = 0, miscompares = 0;

  typedef struct {bit v; bit [7:0] tag; bit [31:0] tgt; int strength;} ent_t;
  ent_t      m [64];
  bit [31:0] m_look, m_mis;

  btb_predictor dut (
    .clk(clk), .rst(rst), .PCF(PCF),
    .BranchPredictedF(BranchPredictedF), .BranchPredictedTargetF(BranchPredictedTargetF),
    .BrInstE(BrInstE), .PCE(PCE), .BranchE(BranchE), .BranchTarget(BranchTarget),
    .BranchPredictedE(BranchPredictedE), .StallE(StallE),
    .LookupCnt(LookupCnt), .MispredCnt(MispredCnt)
  );

  always #5 clk = ~clk;

  function automatic bit m_hit(bit [31:0] pc);
    return m[pc[7:2]].v && m[pc[7:2]].tag == pc[15:8];
  endfunction

  function automatic bit m_taken(bit [31:0] pc);
    return m_hit(pc) && m[pc[7:2]].strength >= 2;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) m[i] = '{1'b0, 8'h0, 32'h0, 1};
    m_look = 0;
    m_mis  = 0;
  endfunction

  function automatic void model_train(bit [31:0] pc, bit taken, bit [31:0] tgt, bit bpe);
    int i = int'(pc[7:2]);
    m_look++;
    if (taken != bpe) m_mis++;
    if (m_hit(pc)) begin
      m[i].strength = taken ? ((m[i].strength < 3) ? m[i].strength + 1 : 3)
                            : ((m[i].strength > 0) ? m[i].strength - 1 : 0);
      if (taken) m[i].tgt = tgt;
    end else if (taken) begin
      m[i] = '{1'b1, pc[15:8], tgt, 2};
    end
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(logic bi, logic [31:0] pf, logic [31:0] pe, logic be,
                       logic [31:0] bt, logic bpe, logic st);
    BrInstE = bi; PCF = pf; PCE = pe; BranchE = be;
    BranchTarget = bt; BranchPredictedE = bpe; StallE = st;
  endtask

  task automatic idle(logic [31:0] pf);
    drive(1'b0, pf, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic cycle();
    bit p;
    #1;
    p = !rst && m_taken(PCF);
    chk("pred",    {31'd0, BranchPredictedF}, {31'd0, p});
    chk("target",  BranchPredictedTargetF, p ? m[PCF[7:2]].tgt : 32'h0);
    chk("lookup",  LookupCnt, m_look);
    chk("mispred", MispredCnt, m_mis);
    @(posedge clk);
    if (rst) model_reset();
    else if (BrInstE && !StallE) model_train(PCE, BranchE, BranchTarget, BranchPredictedE);
    #1;
  endtask

  initial begin
    bit [31:0] pf, pe;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(32'h100); #1;
    chk("rst_pred", {31'd0, BranchPredictedF}, 32'd0);
    chk("rst_tgt", BranchPredictedTargetF, 32'h0);
    chk("rst_look", LookupCnt, 32'd0);
    chk("rst_mis", MispredCnt, 32'd0);
    cycle();
    drive(1, 32'h100, 32'h100, 1, 32'h80, 0, 0); cycle();
    idle(32'h100); #1;
    chk("alloc_pred", {31'd0, BranchPredictedF}, 32'd1);
    chk("alloc_tgt", BranchPredictedTargetF, 32'h80);
    chk("alloc_mis", MispredCnt, 32'd1);
    cycle();
    drive(1, 32'h100, 32'h100, 0, 32'h0, 1, 0); cycle();
    idle(32'h100); #1;
    chk("wn_pred", {31'd0, BranchPredictedF}, 32'd0);
    cycle();
    drive(1, 32'h100, 32'h100, 0, 32'h0, 0, 0); cycle();
    drive(1, 32'h100, 32'h100, 1, 32'h80, 0, 0); cycle();
    idle(32'h100); #1;
    chk("sn_wn_pred", {31'd0, BranchPredictedF}, 32'd0);
    cycle();
    drive(1, 32'h100, 32'h100, 1, 32'h80, 0, 0); cycle();
    idle(32'h100); #1;
    chk("wn_wt_pred", {31'd0, BranchPredictedF}, 32'd1);
    cycle();
    drive(1, 32'h100, 32'h100, 1, 32'h80, 1, 0); cycle();
    drive(1, 32'h100, 32'h200, 1, 32'h200, 0, 0); cycle();
    idle(32'h100); #1;
    chk("alias_old", {31'd0, BranchPredictedF}, 32'd0);
    cycle();
    idle(32'h200); #1;
    chk("alias_new", {31'd0, BranchPredictedF}, 32'd1);
    chk("alias_tgt", BranchPredictedTargetF, 32'h200);
    cycle();
    drive(1, 32'h140, 32'h140, 1, 32'h44, 0, 0); #1;
    chk("same_old", {31'd0, BranchPredictedF}, 32'd0);
    cycle();
    idle(32'h140); #1;
    chk("same_new", BranchPredictedTargetF, 32'h44);
    cycle();
    drive(1, 32'h180, 32'h180, 1, 32'h99, 0, 1); cycle();
    idle(32'h180); #1;
    chk("stall_pred", {31'd0, BranchPredictedF}, 32'd0);
    cycle();
    rst = 1'b1;
    drive(1, 32'h300, 32'h300, 1, 32'h55, 0, 0); cycle();
    rst = 1'b0;
    idle(32'h300); #1;
    chk("rstwin_pred", {31'd0, BranchPredictedF}, 32'd0);
    chk("rstwin_look", LookupCnt, 32'd0);
    cycle();
    for (int n = 0; n < 400; n++) begin
      pf = {16'h0, 6'h0, 2'($urandom_range(0, 3)), 3'h0, 3'($urandom_range(0, 7)), 2'($urandom)};
      pe = {16'h0, 6'h0, 2'($urandom_range(0, 3)), 3'h0, 3'($urandom_range(0, 7)), 2'($urandom)};
      drive(($urandom % 4) != 0, pf, pe, 1'($urandom), $urandom,
            (($urandom % 4) == 0) ? 1'($urandom) : m_taken(pe), ($urandom % 5) == 0);
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
